population_ctrl: RTL and testbench
==================================

# population_ctrl

Run controller for the agent-based SIS disease network. Serially loads an initial infection pattern into the agents over the shared `address`/`initState`/`loadState` bus, then observes all agents' `currState` lines. Produces a per-epoch infected-agent count stream, and stops after a programmed number of epochs or on extinction. Sits between the host/testbench and the agent array, driving the load side of the same interface the agents receive.

## Interface
- `NUM_AGENTS`, 10, number of agents in the array (1..16).
- `ADDR_W`, 4, agent address width; must satisfy 2^ADDR_W >= NUM_AGENTS.
- `EPOCH_W`, 16, width of the epoch count and epoch index.
- `SAMPLE_DIV`, 1, clock cycles between samples during RUN (>= 1).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  single-cycle request to begin a run; accepted only in IDLE.
- `initPattern`  in  NUM_AGENTS  initial state per agent (bit k goes to agent k; 1 = INF); latched on accepted `start`.
- `numEpochs`  in  EPOCH_W  number of samples to take; latched on accepted `start`.
- `agentStates`  in  NUM_AGENTS  concatenated `currState` of agents (bit k = agent k).
- `address`  out  ADDR_W  agent address being loaded.
- `initState`  out  1  state value for the addressed agent.
- `loadState`  out  1  load strobe; agents load `initState` when `address` equals their node address.
- `busy`  out  1  high from the cycle after an accepted `start` until the DONE cycle inclusive.
- `done`  out  1  one-cycle pulse at the end of a run.
- `extinct`  out  1  valid with `done`: the run ended because the infected count reached 0.
- `epochValid`  out  1  one-cycle strobe; `epochIndex` and `infectedCount` are valid.
- `epochIndex`  out  EPOCH_W  index of the reported sample, starting at 0.
- `infectedCount`  out  CNT_W  number of set bits in the sampled `agentStates`; CNT_W = clog2(NUM_AGENTS+1).

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: all strobes low. `start`=1 latches `initPattern` and `numEpochs`, clears the load index, and moves to LOAD.
- LOAD: one agent per cycle for k = 0..NUM_AGENTS-1: `loadState`=1, `address`=k, `initState`=latched bit k. After k = NUM_AGENTS-1, go to RUN if the latched `numEpochs` != 0, otherwise go to DONE with `extinct`=0.
- RUN: take sample 0 in the first RUN cycle, then one sample every SAMPLE_DIV cycles. Each sample registers popcount(`agentStates`) and the current epoch index.
- Run termination, evaluated at every sample:
  - If the count is 0, the sample is the last one; next state is DONE with `extinct`=1.
  - Else if the sample index equals `numEpochs`-1, next state is DONE with `extinct`=0.
  - Extinction takes priority when both conditions hold.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `extinct` holds its value until the next accepted `start`.
- `start` outside IDLE is ignored. Inputs other than `agentStates` are ignored outside IDLE.
- `infectedCount`, `epochIndex` and `address` hold their last values between strobes.

## Timing
- Reset values: `address`=0, `initState`=0, `loadState`=0, `busy`=0, `done`=0, `extinct`=0, `epochValid`=0, `epochIndex`=0, `infectedCount`=0. The FSM resets to IDLE.
- `rst` has priority over everything. Asserting it mid-LOAD or mid-RUN aborts the run the same cycle: no `done` is produced and outputs take their reset values on the next edge.
- Cycle numbering, with `start` sampled at edge 0:
  - `loadState` is high on cycles 1..NUM_AGENTS.
  - The first RUN cycle is NUM_AGENTS+1; `agentStates` then already reflects the loaded pattern.
  - Sample n is taken in cycle NUM_AGENTS+1+n·SAMPLE_DIV.
  - `epochValid` for a sample is asserted in the following cycle (1-cycle latency).
  - `done` is asserted in the cycle after the last sample's `epochValid`.
- With `numEpochs`=0, `done` is asserted in cycle NUM_AGENTS+1 and no `epochValid` is produced.
- Minimum gap from `done` to the next accepted `start`: 1 cycle, since `start` is legal in the IDLE cycle after DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `disease_pkg`:
  - agent state constants SUS=0, INF=1;
  - FSM state enum `ctrl_state_t`;
  - CNT_W computation function.
- Sub-module `popcount` (parameter WIDTH): combinational bit count, registered by the parent. It will be reused by future statistics blocks.
- The sample divider is an internal counter, reset on RUN entry.

## Test plan
- Load walk: `initPattern`=10'b0000100011, `numEpochs`=3, SAMPLE_DIV=1 -> `loadState` high 10 cycles, `address` 0..9, `initState` sequence 1,1,0,0,0,1,0,0,0,0.
- Counting: stub `agentStates` held at 10'h3FF -> `infectedCount`=10 on three strobes, `epochIndex` 0,1,2; `done`=1 with `extinct`=0, one cycle after the third strobe.
- Extinction: stub `agentStates` goes 10'h003 (sample 0), 10'h001 (sample 1), 10'h000 (sample 2), `numEpochs`=100 -> counts 2,1,0; `done` with `extinct`=1 after the strobe with index 2.
- Edge cases:
  - `numEpochs`=0 -> `done` at cycle 11, no `epochValid`.
  - `start` pulsed during RUN -> ignored, run length unchanged.
  - SAMPLE_DIV=4 -> strobes 4 cycles apart.
- Reset mid-run: `rst` asserted during LOAD at k=5 -> `loadState`=0 next cycle, no `done`, all outputs at reset values. A new `start` then reloads from address 0.
- Closed loop with 10 real agents, seed pattern 10'h001 -> `infectedCount` always <= 10, first count = 1, and the run terminates.

Source files
------------

// File: rtl/disease_pkg.sv
// disease_pkg: shared agent-state constants, controller FSM states and count-width helper
package disease_pkg;
  localparam logic SUS = 1'b0;
  localparam logic INF = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ctrl_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/population_ctrl_if.sv
// population_ctrl_if: serial agent load bus driven by the controller, received by the agents
interface population_ctrl_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] address;
  logic              initState;
  logic              loadState;
  modport master(output address, initState, loadState);
  modport slave(input address, initState, loadState);
endinterface

// File: rtl/popcount.sv
// popcount: combinational count of set bits
module popcount
  import disease_pkg::*;
#(
  parameter int WIDTH = 10,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + CW'(in_i[i]);
  end
endmodule

// File: rtl/population_ctrl.sv
// population_ctrl: loads an infection pattern into the agents, then streams per-epoch infected counts
module population_ctrl
  import disease_pkg::*;
#(
  parameter int NUM_AGENTS = 10,
  parameter int ADDR_W = 4,
  parameter int EPOCH_W = 16,
  parameter int SAMPLE_DIV = 1,
  localparam int CNT_W = cnt_w(NUM_AGENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_AGENTS-1:0] initPattern,
  input  logic [EPOCH_W-1:0]    numEpochs,
  input  logic [NUM_AGENTS-1:0] agentStates,
  population_ctrl_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  extinct,
  output logic                  epochValid,
  output logic [EPOCH_W-1:0]    epochIndex,
  output logic [CNT_W-1:0]      infectedCount
);
  localparam int DIV_W = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  ctrl_state_t           state_q;
  logic [NUM_AGENTS-1:0] pat_q;
  logic [EPOCH_W-1:0]    ne_q;
  logic [EPOCH_W-1:0]    idx_q;
  logic [DIV_W-1:0]      div_q;
  logic                  last_q;
  logic [CNT_W-1:0]      cnt;
  popcount #(.WIDTH(NUM_AGENTS)) u_popcount (.in_i(agentStates), .cnt_o(cnt));
  // pat_q shifts right so bit 0 is always the next agent's initial state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      ne_q <= '0;
      idx_q <= '0;
      div_q <= '0;
      last_q <= 1'b0;
      bus.address <= '0;
      bus.initState <= 1'b0;
      bus.loadState <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      extinct <= 1'b0;
      epochValid <= 1'b0;
      epochIndex <= '0;
      infectedCount <= '0;
    end else begin
      epochValid <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          pat_q <= initPattern >> 1;
          ne_q <= numEpochs;
          bus.address <= '0;
          bus.initState <= initPattern[0];
          bus.loadState <= 1'b1;
          busy <= 1'b1;
          extinct <= 1'b0;
        end
        LOAD: if (bus.address == ADDR_W'(NUM_AGENTS - 1)) begin
          bus.loadState <= 1'b0;
          bus.initState <= 1'b0;
          idx_q <= '0;
          div_q <= '0;
          last_q <= 1'b0;
          state_q <= ne_q != '0 ? RUN : DONE;
          done <= ne_q == '0;
        end else begin
          bus.address <= bus.address + 1'b1;
          bus.initState <= pat_q[0];
          pat_q <= pat_q >> 1;
        end
        RUN: begin
          div_q <= div_q == DIV_LAST ? '0 : div_q + 1'b1;
          if (last_q) begin
            state_q <= DONE;
            done <= 1'b1;
          end else if (div_q == '0) begin
            epochValid <= 1'b1;
            infectedCount <= cnt;
            epochIndex <= idx_q;
            idx_q <= idx_q + 1'b1;
            extinct <= cnt == '0;
            last_q <= cnt == '0 || idx_q == ne_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_population_ctrl.sv
// tb_population_ctrl: directed checks of load walk, counting, extinction, divider and reset abort
module tb_population_ctrl;
  import disease_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start1, start4;
  logic [9:0] init_pattern, ag1, ag4, st1, st4;
  logic [9:0] tab [0:3];
  logic [15:0] num_epochs;
  int cyc, mode, ti, n_chk, n_fail;
  bit sel;
  logic busy1, done1, ext1, ev1, busy4, done4, ext4, ev4;
  logic [15:0] idx1, idx4;
  logic [3:0] cnt1, cnt4;
  logic o_lv, o_init, o_busy, o_done, o_ext, o_ev;
  logic [3:0] o_addr, o_cnt;
  logic [15:0] o_idx;
  int ld_addr[$], ld_init[$], ld_cyc[$], ev_cyc[$], ev_cnt[$], ev_idx[$];
  int done_cyc, ext_at_done, ext_after, busy_first, busy_after;
  population_ctrl_if #(.ADDR_W(4)) bus1 ();
  population_ctrl_if #(.ADDR_W(4)) bus4 ();
  population_ctrl #(.NUM_AGENTS(10), .ADDR_W(4), .EPOCH_W(16), .SAMPLE_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .initPattern(init_pattern), .numEpochs(num_epochs),
    .agentStates(st1), .bus(bus1), .busy(busy1), .done(done1), .extinct(ext1),
    .epochValid(ev1), .epochIndex(idx1), .infectedCount(cnt1));
  population_ctrl #(.NUM_AGENTS(10), .ADDR_W(4), .EPOCH_W(16), .SAMPLE_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .initPattern(init_pattern), .numEpochs(num_epochs),
    .agentStates(st4), .bus(bus4), .busy(busy4), .done(done4), .extinct(ext4),
    .epochValid(ev4), .epochIndex(idx4), .infectedCount(cnt4));
  always_ff @(posedge clk) begin
    if (rst) begin
      ag1 <= '0;
      ag4 <= '0;
    end else begin
      if (bus1.loadState) ag1[bus1.address] <= bus1.initState;
      if (bus4.loadState) ag4[bus4.address] <= bus4.initState;
    end
  end
  always_comb begin
    ti = (cyc >= 11 && cyc <= 13) ? cyc - 11 : 3;
    st1 = mode == 0 ? ag1 : mode == 1 ? 10'h3FF : tab[2'(ti)];
    st4 = mode == 0 ? ag4 : 10'h3FF;
    o_lv = sel ? bus4.loadState : bus1.loadState;
    o_addr = sel ? bus4.address : bus1.address;
    o_init = sel ? bus4.initState : bus1.initState;
    o_busy = sel ? busy4 : busy1;
    o_done = sel ? done4 : done1;
    o_ext = sel ? ext4 : ext1;
    o_ev = sel ? ev4 : ev1;
    o_idx = sel ? idx4 : idx1;
    o_cnt = sel ? cnt4 : cnt1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input bit s4, input logic [9:0] pat, input logic [15:0] ne, input int spulse);
    ld_addr.delete(); ld_init.delete(); ld_cyc.delete();
    ev_cyc.delete(); ev_cnt.delete(); ev_idx.delete();
    done_cyc = -1; ext_at_done = -1; ext_after = -1; busy_first = -1; busy_after = -1;
    sel = s4;
    init_pattern = pat;
    num_epochs = ne;
    cyc = 0;
    start1 = !s4;
    start4 = s4;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      cyc = c;
      if (c == 1) busy_first = int'(o_busy);
      if (o_lv) begin
        ld_addr.push_back(int'(o_addr));
        ld_init.push_back(int'(o_init));
        ld_cyc.push_back(c);
      end
      if (o_ev) begin
        ev_cyc.push_back(c);
        ev_cnt.push_back(int'(o_cnt));
        ev_idx.push_back(int'(o_idx));
      end
      if (o_done) begin
        done_cyc = c;
        ext_at_done = int'(o_ext);
      end
      if (done_cyc > 0 && c == done_cyc + 1) begin
        ext_after = int'(o_ext);
        busy_after = int'(o_busy);
        break;
      end
      start1 = !s4 && c == spulse;
      start4 = s4 && c == spulse;
      tick();
    end
    start1 = 1'b0;
    start4 = 1'b0;
  endtask
  initial begin
    int exp_init[10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    int exp_ext[3] = '{2, 1, 0};
    int ndone;
    n_chk = 0; n_fail = 0;
    tab[0] = 10'h003; tab[1] = 10'h001; tab[2] = 10'h000; tab[3] = 10'h000;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    init_pattern = '0; num_epochs = '0; mode = 1; sel = 1'b0; cyc = 0;
    repeat (3) tick();
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_ext", ext1, 0);
    check("rst_ev", ev1, 0);
    check("rst_idx", idx1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_addr", bus1.address, 0);
    check("rst_load", bus1.loadState, 0);
    check("rst_init", bus1.initState, 0);
    check("rst_busy4", busy4, 0);
    rst = 1'b0;
    tick();
    // load walk with loopback agents
    mode = 0;
    run(0, 10'b0000100011, 16'd3, -1);
    check("walk_nload", ld_cyc.size(), 10);
    for (int k = 0; k < 10 && k < ld_cyc.size(); k++) begin
      check($sformatf("walk_addr%0d", k), ld_addr[k], k);
      check($sformatf("walk_init%0d", k), ld_init[k], exp_init[k]);
      check($sformatf("walk_cyc%0d", k), ld_cyc[k], k + 1);
    end
    check("walk_busy1", busy_first, 1);
    check("walk_nev", ev_cyc.size(), 3);
    for (int i = 0; i < ev_cyc.size(); i++) check($sformatf("walk_cnt%0d", i), ev_cnt[i], 3);
    check("walk_done", done_cyc, 15);
    check("walk_busy_after", busy_after, 0);
    // counting with all agents infected
    mode = 1;
    run(0, 10'h000, 16'd3, -1);
    check("cnt_nev", ev_cyc.size(), 3);
    for (int i = 0; i < ev_cyc.size(); i++) begin
      check($sformatf("cnt_cnt%0d", i), ev_cnt[i], 10);
      check($sformatf("cnt_idx%0d", i), ev_idx[i], i);
      check($sformatf("cnt_cyc%0d", i), ev_cyc[i], 12 + i);
    end
    check("cnt_done", done_cyc, 15);
    check("cnt_ext", ext_at_done, 0);
    // extinction before numEpochs
    mode = 2;
    run(0, 10'h000, 16'd100, -1);
    check("ext_nev", ev_cyc.size(), 3);
    for (int i = 0; i < ev_cyc.size() && i < 3; i++) begin
      check($sformatf("ext_cnt%0d", i), ev_cnt[i], exp_ext[i]);
      check($sformatf("ext_idx%0d", i), ev_idx[i], i);
    end
    check("ext_done", done_cyc, 15);
    check("ext_flag", ext_at_done, 1);
    check("ext_hold", ext_after, 1);
    // zero epochs
    mode = 1;
    run(0, 10'h3FF, 16'd0, -1);
    check("zero_nev", ev_cyc.size(), 0);
    check("zero_done", done_cyc, 11);
    check("zero_ext", ext_at_done, 0);
    // start pulsed mid-run is ignored
    run(0, 10'h000, 16'd3, 12);
    check("spulse_nev", ev_cyc.size(), 3);
    check("spulse_done", done_cyc, 15);
    // sample divider of 4
    run(1, 10'h000, 16'd3, -1);
    check("div4_nev", ev_cyc.size(), 3);
    for (int i = 0; i < ev_cyc.size(); i++) check($sformatf("div4_cyc%0d", i), ev_cyc[i], 12 + 4 * i);
    check("div4_done", done_cyc, 21);
    // reset during LOAD at k=5
    sel = 1'b0;
    init_pattern = 10'h3FF;
    num_epochs = 16'd3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    check("abort_addr_before", bus1.address, 5);
    rst = 1'b1;
    tick();
    check("abort_load", bus1.loadState, 0);
    check("abort_busy", busy1, 0);
    check("abort_addr", bus1.address, 0);
    check("abort_init", bus1.initState, 0);
    check("abort_done", done1, 0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done1) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run(0, 10'h3FF, 16'd3, -1);
    check("reload_addr0", ld_addr.size() > 0 ? ld_addr[0] : -1, 0);
    check("reload_done", done_cyc, 15);
    // loopback agents seeded with a single infection
    mode = 0;
    run(0, 10'h001, 16'd5, -1);
    check("loop_first", ev_cnt.size() > 0 ? ev_cnt[0] : -1, 1);
    for (int i = 0; i < ev_cnt.size(); i++) check($sformatf("loop_le10_%0d", i), ev_cnt[i] <= 10, 1);
    check("loop_terminates", done_cyc > 0, 1);
    check("loop_nev", ev_cyc.size(), 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
